// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and forwarding-select encoding for the ID/EX stage
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Youngest producer wins; x0 is resolved by the caller, not here.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] rs,
    input logic [4:0] exmem_rd,
    input logic       exmem_we,
    input logic [4:0] memwb_rd,
    input logic       memwb_we
  );
    if (exmem_we && exmem_rd == rs) return FWD_EXMEM;
    if (memwb_we && memwb_rd == rs) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - operand forwarding select and mux for one EX source operand
module fwd_unit #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs_i,
  input  logic [XLEN-1:0] rf_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic            exmem_reg_write_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic            memwb_reg_write_i,
  input  logic [XLEN-1:0] memwb_wdata_i,
  output logic [XLEN-1:0] op_o
);
  import cpu_pkg::*;

  fwd_sel_e sel;

  always_comb begin
    sel = fwd_select(rs_i, exmem_rd_i, exmem_reg_write_i, memwb_rd_i, memwb_reg_write_i);
  end

  always_comb begin
    op_o = '0;
    if (rs_i != 5'd0) begin
      case (sel)
        FWD_EXMEM: op_o = exmem_result_i;
        FWD_MEMWB: op_o = memwb_wdata_i;
        default:   op_o = rf_i;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush bubble,
// operand forwarding and saturating stall/flush event counters
module id_ex_stage #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic [XLEN-1:0]   id_rdata_a_i,
  input  logic [XLEN-1:0]   id_rdata_b_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic [4:0]        exmem_rd_i,
  input  logic              exmem_reg_write_i,
  input  logic [XLEN-1:0]   exmem_result_i,
  input  logic [4:0]        memwb_rd_i,
  input  logic              memwb_reg_write_i,
  input  logic [XLEN-1:0]   memwb_wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic [XLEN-1:0]   ex_op_a_o,
  output logic [XLEN-1:0]   ex_op_b_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              ex_valid_q;
  logic [XLEN-1:0]   ex_pc_q, ex_imm_q, ex_rdata_a_q, ex_rdata_b_q;
  logic [4:0]        ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic              ex_reg_write_q, ex_mem_read_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              rs_hit, bubble;

  // ex_mem_read_q is already valid-gated, so a bubble in EX cannot raise a stall.
  assign rs_hit  = (id_use_rs1_i && id_rs1_i == ex_rd_q) || (id_use_rs2_i && id_rs2_i == ex_rd_q);
  assign stall_o = !rst_i && ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                   id_valid_i && !flush_i && rs_hit;
  assign bubble  = flush_i || stall_o;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_i && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_imm_q       <= '0;
      ex_rdata_a_q   <= '0;
      ex_rdata_b_q   <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_ctrl_q      <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (bubble) begin
        ex_valid_q     <= 1'b0;
        ex_reg_write_q <= 1'b0;
        ex_mem_read_q  <= 1'b0;
      end else begin
        ex_valid_q     <= id_valid_i;
        ex_pc_q        <= id_pc_i;
        ex_imm_q       <= id_imm_i;
        ex_rdata_a_q   <= id_rdata_a_i;
        ex_rdata_b_q   <= id_rdata_b_i;
        ex_rs1_q       <= id_rs1_i;
        ex_rs2_q       <= id_rs2_i;
        ex_rd_q        <= id_rd_i;
        ex_ctrl_q      <= id_ctrl_i;
        ex_reg_write_q <= id_reg_write_i && id_valid_i;
        ex_mem_read_q  <= id_mem_read_i && id_valid_i;
      end
    end
  end

  fwd_unit #(.XLEN(XLEN)) u_fwd_a (
    .rs_i              (ex_rs1_q),
    .rf_i              (ex_rdata_a_q),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_wdata_i     (memwb_wdata_i),
    .op_o              (ex_op_a_o)
  );

  fwd_unit #(.XLEN(XLEN)) u_fwd_b (
    .rs_i              (ex_rs2_q),
    .rf_i              (ex_rdata_b_q),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_wdata_i     (memwb_wdata_i),
    .op_o              (ex_op_b_o)
  );

  assign ex_valid_o     = ex_valid_q;
  assign ex_pc_o        = ex_pc_q;
  assign ex_imm_o       = ex_imm_q;
  assign ex_rs1_o       = ex_rs1_q;
  assign ex_rs2_o       = ex_rs2_q;
  assign ex_rd_o        = ex_rd_q;
  assign ex_ctrl_o      = ex_ctrl_q;
  assign ex_reg_write_o = ex_reg_write_q;
  assign ex_mem_read_o  = ex_mem_read_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;

  localparam int CNT_W = 4;

  logic        clk, rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [31:0] id_pc, id_rdata_a, id_rdata_b, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [11:0] id_ctrl;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write, flush;
  logic [31:0] exmem_result, memwb_wdata;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [11:0] ex_ctrl;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.XLEN(32), .CTRL_W(12), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_rdata_a_i(id_rdata_a), .id_rdata_b_i(id_rdata_b), .id_imm_i(id_imm),
    .id_ctrl_i(id_ctrl), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .exmem_rd_i(exmem_rd), .exmem_reg_write_i(exmem_reg_write), .exmem_result_i(exmem_result),
    .memwb_rd_i(memwb_rd), .memwb_reg_write_i(memwb_reg_write), .memwb_wdata_i(memwb_wdata),
    .flush_i(flush), .stall_o(stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_imm_o(ex_imm),
    .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_op_a_o(ex_op_a), .ex_op_b_o(ex_op_b),
    .ex_ctrl_o(ex_ctrl), .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of the instruction currently sitting in EX
  logic        m_valid, m_rw, m_mr;
  logic [31:0] m_pc, m_imm, m_ra, m_rb;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [11:0] m_ctrl;
  int          m_scnt, m_fcnt;

  function automatic logic [31:0] ref_op(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (exmem_reg_write && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd == rs) return memwb_wdata;
    return rf;
  endfunction

  function automatic logic ref_stall();
    logic reads_ld;
    reads_ld = (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
    return !rst && m_valid && m_mr && m_rd != 5'd0 && id_valid && !flush && reads_ld;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_pc = 0; m_imm = 0; m_ra = 0; m_rb = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_pc = $urandom; id_imm = $urandom; id_rdata_a = $urandom; id_rdata_b = $urandom;
    id_ctrl = 12'($urandom);
  endtask

  task automatic clear_fwd();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_wdata = 0; flush = 0;
  endtask

  // Entered and left at a negedge with inputs already driven.
  task automatic do_cycle();
    logic s;
    #1;
    s = ref_stall();
    chk("stall", stall, s);
    if (m_valid) begin
      chk("op_a", ex_op_a, ref_op(m_rs1, m_ra));
      chk("op_b", ex_op_b, ref_op(m_rs2, m_rb));
    end
    @(posedge clk);
    if (s && m_scnt < (1 << CNT_W) - 1) m_scnt++;
    if (flush && m_fcnt < (1 << CNT_W) - 1) m_fcnt++;
    if (flush || s) begin
      m_valid = 0; m_rw = 0; m_mr = 0;
    end else begin
      m_valid = id_valid; m_pc = id_pc; m_imm = id_imm; m_ra = id_rdata_a; m_rb = id_rdata_b;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_ctrl = id_ctrl;
      m_rw = id_valid && id_reg_write; m_mr = id_valid && id_mem_read;
    end
    #1;
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_reg_write", ex_reg_write, m_rw);
    chk("ex_mem_read", ex_mem_read, m_mr);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
    if (m_valid) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rs1", ex_rs1, m_rs1);
      chk("ex_rs2", ex_rs2, m_rs2);
      chk("ex_rd", ex_rd, m_rd);
      chk("ex_ctrl", ex_ctrl, m_ctrl);
    end
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks everything cleared without a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_ex_rs1", ex_rs1, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_rw", ex_reg_write, 0);
    chk("rst_ex_mr", ex_mem_read, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_stall", stall, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_fwd();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    do_reset();

    // load-use: lw x5 in EX, add x6,x5,x7 in ID
    drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    do_cycle();
    drive_id(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);
    #1 chk("t2_stall_hi", stall, 1);
    do_cycle();
    chk("t2_bubble", ex_valid, 0);
    chk("t2_stall_cnt", stall_cnt, 1);
    do_cycle();
    chk("t2_add_in_ex", ex_valid, 1);
    chk("t2_add_rd", ex_rd, 6);

    // EX/MEM beats MEM/WB
    drive_id(1, 5'd3, 1, 5'd4, 1, 5'd9, 1, 0);
    do_cycle();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'h11;
    memwb_rd = 3; memwb_reg_write = 1; memwb_wdata = 32'h22;
    #1 chk("t3_op_a", ex_op_a, 32'h11);
    do_cycle();
    clear_fwd();

    // x0 is never forwarded
    drive_id(1, 5'd2, 1, 5'd0, 1, 5'd8, 1, 0);
    id_rdata_b = 32'h55;
    do_cycle();
    memwb_rd = 0; memwb_reg_write = 1; memwb_wdata = 32'hDEAD;
    #1 chk("t4_op_b", ex_op_b, 0);
    do_cycle();
    clear_fwd();

    // flush beats load-use stall
    do_reset();
    drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    do_cycle();
    drive_id(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);
    flush = 1;
    #1 chk("t5_stall_lo", stall, 0);
    do_cycle();
    flush = 0;
    chk("t5_bubble", ex_valid, 0);
    chk("t5_flush_cnt", flush_cnt, 1);
    chk("t5_stall_cnt", stall_cnt, 0);

    // 20 stall events saturate a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
      do_cycle();
      drive_id(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);
      do_cycle();
    end
    chk("t6_stall_sat", stall_cnt, 4'hF);

    // random traffic over a small register set to provoke hazards
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_id(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
               5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), ($urandom_range(0, 9) < 4));
      flush = ($urandom_range(0, 9) == 0);
      exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom); memwb_wdata = $urandom;
      do_cycle();
    end

    // reset mid-run with live state
    drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    flush = 0;
    do_cycle();
    drive_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    do_reset();
    do_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
